// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_unit
//  Description : HI/LO special-register unit. Accepts 64-bit MULT/DIV results
//                from the ALU, holds each one for MD_LATENCY cycles, then
//                commits it to HI/LO. Services MFHI/MFLO reads and MTHI/MTLO
//                writes, and requests a pipeline stall while a result is in
//                flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_unit #(
  parameter int unsigned MD_LATENCY = 4   // accept-to-commit latency, 1..32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hilo_we,
  input  logic [63:0] hilo_in,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        err_collide
);

  // Two-state controller: waiting for a result, or holding one in flight.
  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_pend = 1'b1;

  // Countdown reload value; 6 bits covers the full 1..32 latency range.
  localparam logic [5:0] c_lat = 6'(MD_LATENCY);

  logic [0:0]  state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [63:0] pend_q,  pend_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic        err_q,   err_d;

  logic        w_any_req;

  // State register: all architectural and control flops, reset has priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= c_idle;
      cnt_q   <= 6'd0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept results and MT writes when idle, count down and
  // commit when pending.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    case (state_q)
      c_idle: begin
        if (hilo_we) begin
          // A result always wins over a same-cycle MT write; the MT write is
          // lost, so remember the protocol violation until reset.
          pend_d  = hilo_in;
          cnt_d   = c_lat;
          state_d = c_pend;
          if (mthi || mtlo) begin
            err_d = 1'b1;
          end
        end else begin
          if (mthi) begin
            hi_d = mt_data;
          end
          if (mtlo) begin
            lo_d = mt_data;
          end
        end
      end
      c_pend: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          state_d = c_idle;
        end
      end
      default: begin
        state_d = c_idle;
      end
    endcase
  end

  assign w_any_req = hilo_we | mthi | mtlo | rd_hi | rd_lo;

  // Output logic: stall any HI/LO access while busy; reads see committed
  // values only, never the pending result.
  always_comb begin
    stall   = (state_q == c_pend) & w_any_req;
    rd_data = 32'd0;
    if (rd_hi) begin
      rd_data = hi_q;
    end else if (rd_lo) begin
      rd_data = lo_q;
    end
  end

  assign busy        = (state_q == c_pend);
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign err_collide = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_unit
//  Description : Scoreboard bench for hilo_unit. A driver applies directed and
//                random stimulus, advances a transaction-level model and
//                queues the expected per-cycle response; a monitor pops and
//                compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_unit;

  localparam int LAT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        hilo_we;
  logic [63:0] hilo_in;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
  logic        rd_hi;
  logic        rd_lo;
  logic [31:0] rd_data;
  logic        stall;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        err_collide;

  hilo_unit #(.MD_LATENCY(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .hilo_we     (hilo_we),
    .hilo_in     (hilo_in),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .mt_data     (mt_data),
    .rd_hi       (rd_hi),
    .rd_lo       (rd_lo),
    .rd_data     (rd_data),
    .stall       (stall),
    .busy        (busy),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .err_collide (err_collide)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
    logic        busy;
    logic        stall;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Reference model: architectural HI/LO plus at most one in-flight result
  // tagged with the absolute edge number at which it lands.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          m_err = 1'b0;
  bit          m_inflight = 1'b0;
  logic [63:0] m_val = 64'd0;
  int          m_edges = 0;
  int          m_commit_edge = 0;

  // One cycle: apply inputs, queue the expected response, advance the model.
  task automatic drive(input bit rst, input bit we, input logic [63:0] din,
                       input bit th, input bit tl, input logic [31:0] md,
                       input bit rh, input bit rl);
    exp_t e;
    @(posedge clock);
    #1;
    reset   = rst;
    hilo_we = we;
    hilo_in = din;
    mthi    = th;
    mtlo    = tl;
    mt_data = md;
    rd_hi   = rh;
    rd_lo   = rl;
    e.hi    = m_hi;
    e.lo    = m_lo;
    e.err   = m_err;
    e.busy  = m_inflight;
    e.stall = m_inflight && (we || th || tl || rh || rl);
    e.rd    = rh ? m_hi : (rl ? m_lo : 32'd0);
    sb.push_back(e);
    m_edges++;
    if (rst) begin
      m_hi = 32'd0; m_lo = 32'd0; m_err = 1'b0; m_inflight = 1'b0;
    end else if (m_inflight) begin
      if (m_edges == m_commit_edge) begin
        m_hi = m_val[63:32];
        m_lo = m_val[31:0];
        m_inflight = 1'b0;
      end
    end else if (we) begin
      m_val = din;
      m_inflight = 1'b1;
      m_commit_edge = m_edges + LAT;
      if (th || tl) m_err = 1'b1;
    end else begin
      if (th) m_hi = md;
      if (tl) m_lo = md;
    end
  endtask

  task automatic idle(input int n, input bit rl);
    for (int k = 0; k < n; k++) drive(0, 0, 64'd0, 0, 0, 32'd0, 0, rl);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (vector %0d)", name, act, exp, n_vec);
    end
  endtask

  // Monitor: every cycle the DUT presents a response; compare it mid-cycle.
  exp_t mon_e;
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      chk("hi_out",      hi_out,               mon_e.hi);
      chk("lo_out",      lo_out,               mon_e.lo);
      chk("rd_data",     rd_data,              mon_e.rd);
      chk("busy",        {31'd0, busy},        {31'd0, mon_e.busy});
      chk("stall",       {31'd0, stall},       {31'd0, mon_e.stall});
      chk("err_collide", {31'd0, err_collide}, {31'd0, mon_e.err});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          pwe;
    logic [63:0] pdin;
    bit          we;
    logic [63:0] din;
    reset = 1'b1; hilo_we = 1'b0; hilo_in = 64'd0; mthi = 1'b0; mtlo = 1'b0;
    mt_data = 32'd0; rd_hi = 1'b0; rd_lo = 1'b0;
    repeat (2) @(posedge clock);

    // Post-reset state, MFLO returns 0.
    idle(1, 1);
    // Basic result: read during busy stalls and shows stale LO.
    drive(0, 1, 64'h00000002_00000003, 0, 0, 32'd0, 0, 0);
    idle(LAT + 2, 1);
    // MTHI then MTLO.
    drive(0, 0, 64'd0, 1, 0, 32'hDEADBEEF, 0, 0);
    drive(0, 0, 64'd0, 0, 1, 32'h12345678, 1, 0);
    idle(1, 0);
    // Second result held during PEND, accepted after the first commits.
    drive(0, 1, 64'h13572468_24681357, 0, 0, 32'd0, 0, 0);
    for (int k = 0; k < LAT + 1; k++)
      drive(0, 1, 64'hAAAAAAAA_55555555, 0, 0, 32'd0, 1, 0);
    idle(LAT + 1, 1);
    // Collision: result wins, MTLO dropped, sticky error.
    drive(0, 1, 64'h00000001_00000001, 0, 1, 32'hFFFFFFFF, 0, 0);
    idle(LAT + 2, 1);
    // Divide-by-zero all-zero result commits normally.
    drive(0, 1, 64'd0, 0, 0, 32'd0, 0, 0);
    idle(LAT + 1, 0);
    // Reset mid-PEND discards the result.
    drive(0, 1, 64'hCAFEF00D_BADC0FFE, 0, 0, 32'd0, 0, 0);
    idle(2, 0);
    drive(1, 0, 64'd0, 0, 0, 32'd0, 0, 0);
    drive(1, 0, 64'd0, 0, 0, 32'd0, 0, 0);
    idle(LAT + 3, 1);

    // Random traffic; a stalled producer holds its request and data.
    pwe = 1'b0; pdin = 64'd0;
    for (int i = 0; i < 3000; i++) begin
      if (pwe && m_inflight && ($urandom_range(0, 7) != 0)) begin
        we = 1'b1; din = pdin;
      end else begin
        we  = ($urandom_range(0, 3) == 0);
        din = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      end
      pwe = we; pdin = din;
      drive(($urandom_range(0, 59) == 0), we, din,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), $urandom,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end
    idle(1, 0);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- HI/LO special-register unit at the receiving end of the ALU's 64-bit result path.
- Accepts 64-bit MULT/DIV results when the ALU flags a HI/LO write. Holds each result for a configurable multiply/divide latency, then commits it to the architectural HI (r63) and LO (r62) registers.
- Services MFHI/MFLO reads and MTHI/MTLO writes.
- Drives a stall request to the pipeline while a result is in flight.

Parameters:
- MD_LATENCY, 4, cycles from accepting a HI/LO write to commit; legal range 1..32.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- hilo_we  input  1  HI/LO write request; driven by the ALU's sign_hilo
- hilo_in  input  64  result; [63:32] goes to HI, [31:0] goes to LO; driven by the ALU's out_64
- mthi  input  1  MTHI request
- mtlo  input  1  MTLO request
- mt_data  input  32  MTHI/MTLO source data
- rd_hi  input  1  MFHI read request
- rd_lo  input  1  MFLO read request
- rd_data  output  32  read data, combinational; valid when stall=0
- stall  output  1  pipeline hold request, combinational
- busy  output  1  result in flight, registered
- hi_out  output  32  architectural HI, registered
- lo_out  output  32  architectural LO, registered
- err_collide  output  1  sticky protocol-error flag, registered

Behaviour:
- Reset (synchronous, active-high):
  - hi_out=0, lo_out=0, busy=0, err_collide=0.
  - Pending register=0, countdown=0.
  - Reset takes priority over every other input in the same cycle.
- States:
  - IDLE (busy=0).
  - PEND (busy=1; countdown 6 bits).
- IDLE, hilo_we=1:
  - Capture hilo_in into the pending register.
  - Countdown loads MD_LATENCY; go to PEND.
- PEND:
  - Countdown decrements each edge.
  - On the edge where countdown==1: HI<=pending[63:32], LO<=pending[31:0], busy<=0, go to IDLE.
  - busy is therefore high for exactly MD_LATENCY cycles after the accept edge.
  - MD_LATENCY=1: commit on the edge immediately following the accept edge.
- hilo_we while busy:
  - Not accepted; stall=1.
  - Producer holds hilo_we/hilo_in until stall drops.
  - Accepted in the first IDLE cycle after commit.
- MTHI/MTLO:
  - Applied at the edge when busy=0: HI<=mt_data and/or LO<=mt_data. Both may be asserted together.
  - While busy: stall=1, no write.
- hilo_we together with mthi/mtlo in the same IDLE cycle:
  - hilo_we wins; the mt write is dropped.
  - err_collide sets and stays 1 until reset.
- Reads:
  - rd_data = HI if rd_hi, else LO if rd_lo, else 0. rd_hi wins if both are asserted.
  - While busy with rd_hi or rd_lo asserted: stall=1, rd_data shows the stale register value.
  - No forwarding from the pending register; reads see only committed values.
- stall = busy & (hilo_we | mthi | mtlo | rd_hi | rd_lo).
- Width rules:
  - No arithmetic on data; widths are exact, with no truncation or extension.
  - The ALU's all-zero divide-by-zero result commits like any other result.
- Reset mid-PEND: the pending result is discarded, HI/LO clear to 0, and there is no commit.

Test Plan:
- Reset asserted 2 cycles -> hi_out=0, lo_out=0, busy=0, stall=0, err_collide=0; rd_lo=1 gives rd_data=0.
- MD_LATENCY=4, hilo_we=1 for one cycle with hilo_in=0x00000002_00000003:
  - busy high for 4 cycles.
  - rd_lo during busy -> stall=1, rd_data=0.
  - After commit: hi_out=0x2, lo_out=0x3, rd_lo gives 0x3, stall=0.
- Idle, mthi=1, mt_data=0xDEADBEEF -> next cycle hi_out=0xDEADBEEF, lo_out unchanged. Then mtlo=1, mt_data=0x12345678 -> lo_out=0x12345678.
- Second hilo_we held high during PEND with hilo_in=0xAAAAAAAA_55555555:
  - stall=1 throughout PEND.
  - First result commits; second is accepted the following cycle.
  - After 4 more cycles: hi_out=0xAAAAAAAA, lo_out=0x55555555.
- Idle cycle with hilo_we=1 (hilo_in=0x1_00000001) and mtlo=1 (mt_data=0xFFFFFFFF):
  - err_collide=1 and stays set.
  - After commit lo_out=0x00000001 (mt write dropped).
- Reset asserted 2 cycles into PEND -> busy=0, hi_out=lo_out=0 next cycle; no later commit occurs.
